// File: rtl/fft_cen_ctrl_p.sv
// Central sequencer for the radix-16 in-place FFT: external load, pipeline fill,
// NUM_STAGES butterfly passes with drain/refill, then twiddle-multiplied read-out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INI      | idle, counters held at zero, waiting for first ext_valid
// LD_EXTD  | writing external words into SRAM, stalls on !ext_valid
// LD_EXTDF | last external word written, AGU starts
// LD_FILL  | butterfly pipeline fill, FILL_LEN cycles
// RUN      | butterfly stage, STAGE_LEN cycles (+FILL_LEN drain on last)
// WR_FIN   | pipeline drain with write-final enabled, FILL_LEN+1 cycles
// REFILL   | pipeline refill before next stage, FILL_LEN+1 cycles
// SET_OP   | result read-out, advances on out_ready
// SET_OPF  | final read-out beat, frame done
module fft_cen_ctrl_p #(
    parameter int A_WIDTH    = 9,
    parameter int LD_LAST    = 511,
    parameter int FILL_LEN   = 47,
    parameter int STAGE_LEN  = 1024,
    parameter int NUM_STAGES = 4,
    parameter int OUT_LEN    = 1025,
    parameter int C_WIDTH    = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ext_valid,
    input  logic               bnd_in,
    input  logic               out_ready,
    input  logic               abort,
    output logic [3:0]         state,
    output logic [2:0]         stage_idx,
    output logic               cen_out,
    output logic               wen0_out,
    output logic               wen1_out,
    output logic               sd_sel_out,
    output logic [A_WIDTH-1:0] ext_ma_out,
    output logic               agu_en_out,
    output logic               rom_cen_out,
    output logic               rc_sel_out,
    output logic               m2_sel_out,
    output logic               wrfd_en_out,
    output logic               mul_valid_out,
    output logic               done
);

    typedef enum logic [3:0] {
        INI      = 4'd0,
        LD_EXTD  = 4'd1,
        LD_EXTDF = 4'd2,
        LD_FILL  = 4'd3,
        RUN      = 4'd4,
        WR_FIN   = 4'd5,
        REFILL   = 4'd6,
        SET_OP   = 4'd7,
        SET_OPF  = 4'd8
    } state_t;

    localparam logic [A_WIDTH-1:0] MA_LAST        = A_WIDTH'(LD_LAST);
    localparam logic [5:0]         FCNT_FILL_END  = 6'(FILL_LEN - 1);
    localparam logic [5:0]         FCNT_WAIT_END  = 6'(FILL_LEN);
    localparam logic [C_WIDTH-1:0] SCNT_STAGE_END = C_WIDTH'(STAGE_LEN - 1);
    localparam logic [C_WIDTH-1:0] SCNT_LAST_END  = C_WIDTH'(STAGE_LEN - 1 + FILL_LEN);
    localparam logic [C_WIDTH-1:0] OCNT_END       = C_WIDTH'(OUT_LEN - 1);
    localparam logic [2:0]         LAST_STAGE     = 3'(NUM_STAGES - 1);

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   ext_ma_q, ext_ma_d;
    logic [5:0]           fcnt_q, fcnt_d;
    logic [C_WIDTH-1:0]   scnt_q, scnt_d;
    logic [C_WIDTH-1:0]   ocnt_q, ocnt_d;
    logic [2:0]           stage_q, stage_d;
    logic                 m2_sel_q;
    logic                 last_stage;
    logic                 wen0, wen1;

    assign last_stage = (stage_q == LAST_STAGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INI;
            ext_ma_q <= '0;
            fcnt_q   <= '0;
            scnt_q   <= '0;
            ocnt_q   <= '0;
            stage_q  <= '0;
            m2_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ext_ma_q <= ext_ma_d;
            fcnt_q   <= fcnt_d;
            scnt_q   <= scnt_d;
            ocnt_q   <= ocnt_d;
            stage_q  <= stage_d;
            m2_sel_q <= (state_q == SET_OP);
        end
    end

    always_comb begin
        state_d  = state_q;
        ext_ma_d = ext_ma_q;
        fcnt_d   = fcnt_q;
        scnt_d   = scnt_q;
        ocnt_d   = ocnt_q;
        stage_d  = stage_q;

        case (state_q)
            INI: begin
                if (ext_valid) state_d = LD_EXTD;
            end
            LD_EXTD: begin
                if (ext_valid) begin
                    ext_ma_d = ext_ma_q + A_WIDTH'(1);
                    if (ext_ma_q == MA_LAST) state_d = LD_EXTDF;
                end
            end
            LD_EXTDF: state_d = LD_FILL;
            LD_FILL: begin
                fcnt_d = fcnt_q + 6'd1;
                if (fcnt_q >= FCNT_FILL_END) state_d = RUN;
            end
            RUN: begin
                scnt_d = scnt_q + C_WIDTH'(1);
                // the last stage keeps running to flush the pipeline before read-out
                if (last_stage) begin
                    if (scnt_q == SCNT_LAST_END) state_d = SET_OP;
                end else if (scnt_q == SCNT_STAGE_END) begin
                    state_d = WR_FIN;
                end
            end
            WR_FIN: begin
                fcnt_d = fcnt_q + 6'd1;
                if (fcnt_q >= FCNT_WAIT_END) state_d = REFILL;
            end
            REFILL: begin
                fcnt_d = fcnt_q + 6'd1;
                if (fcnt_q >= FCNT_WAIT_END) begin
                    state_d = RUN;
                    stage_d = stage_q + 3'd1;
                    scnt_d  = '0;
                end
            end
            SET_OP: begin
                if (out_ready) begin
                    ocnt_d = ocnt_q + C_WIDTH'(1);
                    if (ocnt_q == OCNT_END) state_d = SET_OPF;
                end
            end
            SET_OPF: state_d = INI;
            default: state_d = INI;
        endcase

        if (state_d != state_q) fcnt_d = '0;

        if (abort) state_d = INI;

        // counters read zero on every INI cycle, including the first one after a frame
        if (state_d == INI) begin
            ext_ma_d = '0;
            fcnt_d   = '0;
            scnt_d   = '0;
            ocnt_d   = '0;
            stage_d  = '0;
        end
    end

    always_comb begin
        wen0 = 1'b1;
        wen1 = 1'b1;
        case (state_q)
            RUN, WR_FIN: begin
                wen0 = bnd_in;
                wen1 = ~bnd_in;
            end
            LD_EXTD: begin
                wen0 = ~ext_valid;
                wen1 = ~ext_valid;
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign stage_idx     = stage_q;
    assign ext_ma_out    = ext_ma_q;
    assign cen_out       = (state_q == INI);
    assign wen0_out      = wen0;
    assign wen1_out      = wen1;
    assign sd_sel_out    = (state_q == INI) || (state_q == LD_EXTD);
    assign agu_en_out    = (state_q == LD_EXTDF) || (state_q == LD_FILL) ||
                           (state_q == RUN) || (state_q == REFILL) ||
                           ((state_q == SET_OP) && out_ready);
    assign rom_cen_out   = (state_q == INI) || (state_q == LD_EXTD) ||
                           (state_q == SET_OP) || (state_q == SET_OPF);
    assign rc_sel_out    = (state_q == SET_OP);
    assign m2_sel_out    = m2_sel_q;
    assign wrfd_en_out   = (state_q == WR_FIN);
    // the first accepted read-out beat only primes the multiplier
    assign mul_valid_out = ((state_q == SET_OP) && out_ready && (ocnt_q != '0)) ||
                           (state_q == SET_OPF);
    assign done          = (state_q == SET_OPF);

endmodule

// File: tb/tb_fft_cen_ctrl_p.sv
// Scoreboard bench for fft_cen_ctrl_p: frames are planned as phase schedules,
// expected per-cycle outputs and per-frame totals are queued and checked by a monitor.
module tb_fft_cen_ctrl_p;

    localparam int A_WIDTH    = 9;
    localparam int LD_LAST    = 7;
    localparam int FILL_LEN   = 3;
    localparam int STAGE_LEN  = 8;
    localparam int NUM_STAGES = 2;
    localparam int OUT_LEN    = 5;
    localparam int C_WIDTH    = 13;

    localparam logic [3:0] S_INI      = 4'd0;
    localparam logic [3:0] S_LD_EXTD  = 4'd1;
    localparam logic [3:0] S_LD_EXTDF = 4'd2;
    localparam logic [3:0] S_LD_FILL  = 4'd3;
    localparam logic [3:0] S_RUN      = 4'd4;
    localparam logic [3:0] S_WR_FIN   = 4'd5;
    localparam logic [3:0] S_REFILL   = 4'd6;
    localparam logic [3:0] S_SET_OP   = 4'd7;
    localparam logic [3:0] S_SET_OPF  = 4'd8;

    // {state, stage, cen, wen0, wen1, sd_sel, agu, rom_cen, rc_sel, m2_sel, wrfd, mul_valid, done}
    localparam logic [17:0] RST_VEC = {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_valid = 1'b0;
    logic bnd_in = 1'b0;
    logic out_ready = 1'b0;
    logic abort = 1'b0;

    logic [3:0]         state;
    logic [2:0]         stage_idx;
    logic               cen_out, wen0_out, wen1_out, sd_sel_out;
    logic [A_WIDTH-1:0] ext_ma_out;
    logic               agu_en_out, rom_cen_out, rc_sel_out, m2_sel_out;
    logic               wrfd_en_out, mul_valid_out, done;
    logic [17:0]        act_vec;

    fft_cen_ctrl_p #(
        .A_WIDTH(A_WIDTH), .LD_LAST(LD_LAST), .FILL_LEN(FILL_LEN), .STAGE_LEN(STAGE_LEN),
        .NUM_STAGES(NUM_STAGES), .OUT_LEN(OUT_LEN), .C_WIDTH(C_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .ext_valid(ext_valid), .bnd_in(bnd_in),
        .out_ready(out_ready), .abort(abort), .state(state), .stage_idx(stage_idx),
        .cen_out(cen_out), .wen0_out(wen0_out), .wen1_out(wen1_out),
        .sd_sel_out(sd_sel_out), .ext_ma_out(ext_ma_out), .agu_en_out(agu_en_out),
        .rom_cen_out(rom_cen_out), .rc_sel_out(rc_sel_out), .m2_sel_out(m2_sel_out),
        .wrfd_en_out(wrfd_en_out), .mul_valid_out(mul_valid_out), .done(done)
    );

    assign act_vec = {state, stage_idx, cen_out, wen0_out, wen1_out, sd_sel_out, agu_en_out,
                      rom_cen_out, rc_sel_out, m2_sel_out, wrfd_en_out, mul_valid_out, done};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]         st;
        logic               ev;
        logic               rdy;
        logic               bnd;
        logic               abrt;
        logic [A_WIDTH-1:0] ma;
        bit                 chk_ma;
        logic [2:0]         stg;
        bit                 opos;
    } cyc_t;

    typedef struct {
        logic [17:0]        vec;
        logic [A_WIDTH-1:0] ma;
        bit                 chk_ma;
    } exp_t;

    typedef struct {
        int len;
        int mul;
        int wrfd;
    } frm_t;

    cyc_t cyc_q[$];
    exp_t sb_q[$];
    frm_t frm_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cycle_no = 0;
    logic [3:0] prev_st = S_INI;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cycle_no, act, exp_v);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Output decode taken from the behavioural description of each phase.
    function automatic logic [17:0] model_out(input cyc_t c, input logic [3:0] prev);
        logic cen = 1'b0, w0 = 1'b1, w1 = 1'b1, sd = 1'b0, agu = 1'b0, rom = 1'b0;
        logic rc = 1'b0, wrfd = 1'b0, mul = 1'b0, dn = 1'b0;
        case (c.st)
            S_INI:                            begin cen = 1'b1; sd = 1'b1; rom = 1'b1; end
            S_LD_EXTD:                        begin w0 = ~c.ev; w1 = ~c.ev; sd = 1'b1; rom = 1'b1; end
            S_LD_EXTDF, S_LD_FILL, S_REFILL:  agu = 1'b1;
            S_RUN:                            begin w0 = c.bnd; w1 = ~c.bnd; agu = 1'b1; end
            S_WR_FIN:                         begin w0 = c.bnd; w1 = ~c.bnd; wrfd = 1'b1; end
            S_SET_OP:                         begin agu = c.rdy; rom = 1'b1; rc = 1'b1; mul = c.rdy & c.opos; end
            S_SET_OPF:                        begin rom = 1'b1; mul = 1'b1; dn = 1'b1; end
            default: ;
        endcase
        return {c.st, c.stg, cen, w0, w1, sd, agu, rom, rc, (prev == S_SET_OP), wrfd, mul, dn};
    endfunction

    task automatic add(input logic [3:0] st, input logic ev, input logic rdy, input int ma,
                       input bit chk_ma, input int stg, input bit opos);
        cyc_t c;
        c.st = st; c.ev = ev; c.rdy = rdy; c.bnd = rb(); c.abrt = 1'b0;
        c.ma = A_WIDTH'(ma); c.chk_ma = chk_ma; c.stg = 3'(stg); c.opos = opos;
        cyc_q.push_back(c);
    endtask

    // Plan one frame as a phase schedule; cut_mode 1 truncates at a named phase, 2 at random.
    task automatic build_frame(input int n_idle, input logic [15:0] stall_mask, input int stall_pct,
                               input bit alt_rdy, input int nrdy_pct, input int cut_mode,
                               input logic [3:0] cut_st, input int cut_stg, input int cut_off,
                               input bit cut_abort);
        int stalls = 0, nrdy = 0, ns, nr, cut;
        cyc_t c;
        frm_t f;
        cyc_q.delete();
        repeat (n_idle) add(S_INI, 1'b0, rb(), 0, 1'b1, 0, 1'b0);
        add(S_INI, 1'b1, rb(), 0, 1'b1, 0, 1'b0);
        for (int a = 0; a <= LD_LAST; a++) begin
            ns = stall_mask[a] ? 1 :
                 ((int'($urandom_range(0, 99)) < stall_pct) ? int'($urandom_range(1, 2)) : 0);
            stalls += ns;
            repeat (ns) add(S_LD_EXTD, 1'b0, rb(), a, 1'b1, 0, 1'b0);
            add(S_LD_EXTD, 1'b1, rb(), a, 1'b1, 0, 1'b0);
        end
        add(S_LD_EXTDF, rb(), rb(), 0, 1'b0, 0, 1'b0);
        repeat (FILL_LEN) add(S_LD_FILL, rb(), rb(), 0, 1'b0, 0, 1'b0);
        for (int s = 0; s < NUM_STAGES; s++) begin
            repeat (STAGE_LEN + ((s == NUM_STAGES - 1) ? FILL_LEN : 0))
                add(S_RUN, rb(), rb(), 0, 1'b0, s, 1'b0);
            if (s < NUM_STAGES - 1) begin
                repeat (FILL_LEN + 1) add(S_WR_FIN, rb(), rb(), 0, 1'b0, s, 1'b0);
                repeat (FILL_LEN + 1) add(S_REFILL, rb(), rb(), 0, 1'b0, s, 1'b0);
            end
        end
        for (int i = 0; i < OUT_LEN; i++) begin
            nr = alt_rdy ? ((i > 0) ? 1 : 0) :
                 ((int'($urandom_range(0, 99)) < nrdy_pct) ? int'($urandom_range(1, 3)) : 0);
            nrdy += nr;
            repeat (nr) add(S_SET_OP, rb(), 1'b0, 0, 1'b0, NUM_STAGES - 1, i > 0);
            add(S_SET_OP, rb(), 1'b1, 0, 1'b0, NUM_STAGES - 1, i > 0);
        end
        add(S_SET_OPF, rb(), rb(), 0, 1'b0, NUM_STAGES - 1, 1'b0);

        cut = -1;
        if (cut_mode == 1) begin
            for (int k = 0; k < cyc_q.size(); k++)
                if (cut < 0 && cyc_q[k].st == cut_st && cyc_q[k].stg == 3'(cut_stg)) cut = k + cut_off;
        end else if (cut_mode == 2) begin
            cut = int'($urandom_range(0, cyc_q.size() - 2));
        end

        if (cut >= 0) begin
            while (cyc_q.size() > cut + 1) void'(cyc_q.pop_back());
            c = cyc_q.pop_back();
            c.abrt = cut_abort;
            cyc_q.push_back(c);
        end else begin
            // cycles from first LD_EXTD to SET_OPF, summed phase by phase
            f.len  = (LD_LAST + 1 + stalls) + 1 + FILL_LEN + NUM_STAGES * STAGE_LEN + FILL_LEN
                     + (NUM_STAGES - 1) * 2 * (FILL_LEN + 1) + OUT_LEN + nrdy;
            f.mul  = OUT_LEN;
            f.wrfd = (NUM_STAGES - 1) * (FILL_LEN + 1);
            frm_q.push_back(f);
        end
    endtask

    task automatic drive();
        cyc_t c;
        exp_t e;
        while (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            @(posedge clk);
            #1;
            ext_valid = c.ev;
            out_ready = c.rdy;
            bnd_in    = c.bnd;
            abort     = c.abrt;
            e.vec     = model_out(c, prev_st);
            e.ma      = c.ma;
            e.chk_ma  = c.chk_ma;
            sb_q.push_back(e);
            prev_st   = c.st;
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2;
        chk("pre_rst_state", 32'(state), 32'(S_WR_FIN));
        rst = 1'b1;
        ext_valid = 1'b0;
        abort = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(act_vec), 32'(RST_VEC));
        chk("async_rst_ext_ma", 32'(ext_ma_out), 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_outputs", 32'(act_vec), 32'(RST_VEC));
        @(negedge clk);
        #2;
        rst = 1'b0;
        prev_st = S_INI;
    endtask

    // Monitor: per-cycle scoreboard plus per-frame totals on every done pulse.
    exp_t m_e;
    frm_t m_f;
    bit   in_frame = 1'b0;
    int   f_len = 0, f_mul = 0, f_wrfd = 0;

    initial begin
        forever begin
            @(negedge clk);
            cycle_no++;
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (sb_q.size() > 0) begin
                    m_e = sb_q.pop_front();
                    chk("cycle_outputs", 32'(act_vec), 32'(m_e.vec));
                    if (m_e.chk_ma) chk("ext_ma_out", 32'(ext_ma_out), 32'(m_e.ma));
                end
                if (state == S_INI) begin
                    in_frame = 1'b0;
                end else if (!in_frame && state == S_LD_EXTD) begin
                    in_frame = 1'b1;
                    f_len = 0; f_mul = 0; f_wrfd = 0;
                end else if (in_frame) begin
                    f_len++;
                end
                if (in_frame) begin
                    f_mul  += int'(mul_valid_out);
                    f_wrfd += int'(wrfd_en_out);
                end
                if (done) begin
                    chk("done_has_frame", 32'(frm_q.size() > 0), 32'd1);
                    if (frm_q.size() > 0) begin
                        m_f = frm_q.pop_front();
                        chk("frame_len", 32'(f_len), 32'(m_f.len));
                        chk("frame_mul_valid", 32'(f_mul), 32'(m_f.mul));
                        chk("frame_wrfd", 32'(f_wrfd), 32'(m_f.wrfd));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 32'(act_vec), 32'(RST_VEC));
        chk("reset_ext_ma", 32'(ext_ma_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // nominal frame
        build_frame(2, 16'h0000, 0, 1'b0, 0, 0, S_INI, 0, 0, 1'b0);
        drive();
        // three stalled load cycles
        build_frame(1, 16'h0034, 0, 1'b0, 0, 0, S_INI, 0, 0, 1'b0);
        drive();
        // out_ready toggling during read-out
        build_frame(0, 16'h0000, 0, 1'b1, 0, 0, S_INI, 0, 0, 1'b0);
        drive();
        // abort inside RUN of stage 1, then a clean frame
        build_frame(1, 16'h0000, 0, 1'b0, 0, 1, S_RUN, 1, 2, 1'b1);
        drive();
        build_frame(0, 16'h0000, 0, 1'b0, 0, 0, S_INI, 0, 0, 1'b0);
        drive();
        // reset asserted during WR_FIN
        build_frame(0, 16'h0000, 0, 1'b0, 0, 1, S_WR_FIN, 0, 0, 1'b0);
        drive();
        rst_pulse();
        // randomized frames with stalls, backpressure and occasional aborts
        for (int n = 0; n < 12; n++) begin
            build_frame(int'($urandom_range(0, 2)), 16'h0000, 30, 1'b0, 40,
                        ($urandom_range(0, 3) == 0) ? 2 : 0, S_INI, 0, 0, 1'b1);
            drive();
        end
        cyc_q.delete();
        repeat (3) add(S_INI, 1'b0, rb(), 0, 1'b1, 0, 1'b0);
        drive();

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("frames_completed", 32'(frm_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
